tmr_fault_monitor: RTL and testbench
====================================

# tmr_fault_monitor

Downstream consumer of the TMR voter in the RS5 core. Samples the three replica results, the voted result and the per-replica fault flags. Keeps saturating fault statistics and detects persistent (consecutive) replica faults. Logs every faulty sample into a small event FIFO drained through a valid/ready handshake, and drives a recovery request/acknowledge handshake toward the reset/resync controller.

## Interface

Parameters:
- PERSIST_THRESH, 4: consecutive faulty samples that mark a replica persistent (range 1..255)
- FIFO_DEPTH, 8: event FIFO entries (power of two, ≥2)
- CNT_WIDTH, 16: width of fault statistics counters

Ports:
- clk  in  1  core clock; all state updates on rising edge
- sys_reset_i  in  1  synchronous, active-high reset
- valid_i  in  1  voter outputs below are valid this cycle
- result_voted_i  in  32  voted result
- fault_A_i / fault_B_i / fault_C_i  in  1 each  replica disagrees with vote
- system_fault_i  in  1  no majority (all three differ)
- fail_count_A_o / fail_count_B_o / fail_count_C_o / fail_count_sys_o  out  CNT_WIDTH each  saturating counts of faulty valid samples
- persistent_o  out  3  {C,B,A} persistent-fault flags
- evt_valid_o  out  1  FIFO head valid
- evt_ready_i  in  1  consumer accepts head
- evt_mask_o  out  4  {sys,C,B,A} fault mask of head entry
- evt_data_o  out  32  voted result of head entry
- evt_time_o  out  32  cycle timestamp of head entry
- overflow_o  out  1  sticky: an event was dropped
- recover_req_o  out  1  recovery request
- recover_ack_i  in  1  recovery acknowledge

## Operation

- Timestamp: free-running 32-bit cycle counter, 0 in the cycle after reset, +1 every cycle, wraps 0xFFFFFFFF→0.
- Sample: a cycle with valid_i=1. Mask = {system_fault_i, fault_C_i, fault_B_i, fault_A_i}. Samples with valid_i=0 are ignored entirely: no count, no streak change, no event.
- Statistics: each fail_count_X_o increments by 1 on a sample with its mask bit set. Saturates at all-ones, no wrap.
- Streaks: per replica A/B/C, an internal 8-bit streak.
  - Sample with the bit set: streak +1, saturating at PERSIST_THRESH.
  - Sample with the bit clear: streak ← 0.
  - persistent_o[x] sets when streak reaches PERSIST_THRESH. It stays set until cleared by the recovery FSM. A clean sample does not clear it.
- Event FIFO: a sample with mask≠0 pushes {mask, result_voted_i, timestamp}. Show-ahead: the head is presented on evt_* while evt_valid_o=1. Pop occurs when evt_valid_o & evt_ready_i.
  - Full, no pop: push dropped, overflow_o ← 1.
  - Full with simultaneous pop: push accepted, no overflow.
  - Empty with push: no bypass; entry visible next cycle.
- overflow_o is cleared only by reset.
- Recovery FSM, states IDLE, REQ, CLEAR:
  - IDLE→REQ when any persistent_o bit is set or a sample has system_fault_i=1.
  - REQ holds recover_req_o=1 until recover_ack_i=1, then →CLEAR. Samples during REQ are still counted and logged.
  - CLEAR lasts one cycle. It zeroes all streaks and persistent_o, then →IDLE. A faulty sample in the CLEAR cycle is counted and logged, but its streak effect is discarded.
  - recover_ack_i is ignored outside REQ.
- Fail counters and FIFO contents are not affected by recovery.

## Timing

- Reset values: all counters 0, timestamp 0, persistent_o 0, evt_valid_o 0, evt_mask_o/evt_data_o/evt_time_o 0, overflow_o 0, recover_req_o 0, FSM IDLE, FIFO empty.
- Reset asserted mid-operation discards FIFO contents and any pending request in the same edge.
- Sample at edge N: fail counts, streaks and persistent_o update at N. evt_valid_o=1 after N if the FIFO was empty.
- persistent_o or system fault sets at edge N → FSM enters REQ at N+1 → recover_req_o=1 from N+1.
- recover_ack_i high at edge M while in REQ: recover_req_o=0 and CLEAR after M; persistent_o=0 after M+1; IDLE after M+1.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Test plan

- Reset then idle 10 cycles → all outputs 0, evt_valid_o=0; timestamp internal value 10.
- Single sample fault_B_i=1, result_voted_i=0xDEADBEEF at timestamp 20, evt_ready_i=1 → one event, mask 0x2, data 0xDEADBEEF, time 20. fail_count_B_o=1, persistent_o=0.
- Four consecutive samples fault_A_i=1 (THRESH=4) → persistent_o=0b001 after the 4th. recover_req_o=1 next cycle. Ack 3 cycles later → req drops, persistent_o=0 one cycle after; fail_count_A_o stays 4.
- A-fault streak of 3, then a clean sample, then 3 more faults → persistent_o stays 0.
- evt_ready_i=0, 10 faulty samples (DEPTH=8) → 8 entries retained, overflow_o=1. Drain → timestamps of the first 8 in order. Push and pop in the same cycle while full → no drop.
- system_fault_i=1 on one sample → mask 0x8, fail_count_sys_o=1, recover_req_o=1 next cycle. Reset asserted while in REQ → all outputs return to reset values the next cycle.

Source files
------------

// File: rtl/tmr_fault_monitor.sv
// tmr_fault_monitor
// Observes the TMR voter outputs: keeps saturating per-replica and system
// fault statistics, flags replicas that fail on consecutive samples, logs
// every faulty sample into a show-ahead event FIFO and requests a recovery
// from the reset/resync controller when a replica is persistently bad or
// the voter reports no majority.
module tmr_fault_monitor #(
  parameter int PERSIST_THRESH = 4,
  parameter int FIFO_DEPTH     = 8,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                 clk,
  input  logic                 sys_reset_i,
  input  logic                 valid_i,
  input  logic [31:0]          result_voted_i,
  input  logic                 fault_A_i,
  input  logic                 fault_B_i,
  input  logic                 fault_C_i,
  input  logic                 system_fault_i,
  output logic [CNT_WIDTH-1:0] fail_count_A_o,
  output logic [CNT_WIDTH-1:0] fail_count_B_o,
  output logic [CNT_WIDTH-1:0] fail_count_C_o,
  output logic [CNT_WIDTH-1:0] fail_count_sys_o,
  output logic [2:0]           persistent_o,
  output logic                 evt_valid_o,
  input  logic                 evt_ready_i,
  output logic [3:0]           evt_mask_o,
  output logic [31:0]          evt_data_o,
  output logic [31:0]          evt_time_o,
  output logic                 overflow_o,
  output logic                 recover_req_o,
  input  logic                 recover_ack_i
);

  localparam int                   AW        = $clog2(FIFO_DEPTH);
  localparam logic [7:0]           THRESH    = 8'(PERSIST_THRESH);
  localparam logic [7:0]           THRESH_M1 = THRESH - 8'd1;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX   = '1;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1);
  localparam logic [AW:0]          PTR_ONE   = (AW + 1)'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    CLEAR = 2'd2
  } state_t;

  typedef struct packed {
    logic [3:0]  mask;
    logic [31:0] data;
    logic [31:0] stamp;
  } evt_t;

  logic [31:0]          timestamp;
  logic [3:0]           sample_mask;
  logic [CNT_WIDTH-1:0] fail_cnt [4];
  logic [7:0]           streak [3];
  logic [2:0]           persistent_q;
  logic                 sys_seen_q;
  state_t               state_q, state_d;
  logic                 req_q;
  evt_t                 mem [FIFO_DEPTH];
  evt_t                 head;
  logic [AW:0]          wr_ptr, rd_ptr;
  logic                 empty, full, push, pop, push_ok;
  logic                 overflow_q;

  // Bit order matches evt_mask_o: {sys, C, B, A}.
  assign sample_mask = {system_fault_i, fault_C_i, fault_B_i, fault_A_i};

  // Free-running cycle counter used to timestamp events.
  // NOTE: state is updated with non-blocking assignments so every flop
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (sys_reset_i) timestamp <= '0;
    else             timestamp <= timestamp + 32'd1;
  end

  // Saturating fault statistics, one counter per mask bit.
  always_ff @(posedge clk) begin
    if (sys_reset_i) begin
      for (int i = 0; i < 4; i++) fail_cnt[i] <= '0;
    end else if (valid_i) begin
      for (int i = 0; i < 4; i++) begin
        if (sample_mask[i] && fail_cnt[i] != CNT_MAX) fail_cnt[i] <= fail_cnt[i] + CNT_ONE;
      end
    end
  end

  assign fail_count_A_o   = fail_cnt[0];
  assign fail_count_B_o   = fail_cnt[1];
  assign fail_count_C_o   = fail_cnt[2];
  assign fail_count_sys_o = fail_cnt[3];

  // Consecutive-fault streaks; CLEAR wipes them and overrides any sample.
  always_ff @(posedge clk) begin
    if (sys_reset_i || state_q == CLEAR) begin
      for (int i = 0; i < 3; i++) streak[i] <= '0;
      persistent_q <= '0;
    end else if (valid_i) begin
      for (int i = 0; i < 3; i++) begin
        if (sample_mask[i]) begin
          if (streak[i] != THRESH) streak[i] <= streak[i] + 8'd1;
          // This sample brings the streak to the threshold (or it is already there).
          if (streak[i] >= THRESH_M1) persistent_q[i] <= 1'b1;
        end else begin
          streak[i] <= '0;
        end
      end
    end
  end

  assign persistent_o = persistent_q;

  // Recovery FSM state, request flop and one-cycle record of a no-majority sample.
  always_ff @(posedge clk) begin
    if (sys_reset_i) begin
      state_q    <= IDLE;
      req_q      <= 1'b0;
      sys_seen_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      req_q      <= (state_d == REQ);
      sys_seen_q <= valid_i & system_fault_i;
    end
  end

  // Recovery FSM next-state logic.
  always_comb begin
    // NOTE: default first so no path leaves state_d unassigned (no latch).
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (|persistent_q || sys_seen_q) state_d = REQ;
      REQ:     if (recover_ack_i) state_d = CLEAR;
      CLEAR:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign recover_req_o = req_q;

  // Event FIFO control: extra pointer bit distinguishes full from empty.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop     = !empty && evt_ready_i;
  assign push    = valid_i && (|sample_mask);
  assign push_ok = push && (!full || pop);

  // FIFO pointers and sticky overflow flag.
  always_ff @(posedge clk) begin
    if (sys_reset_i) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)     rd_ptr <= rd_ptr + PTR_ONE;
      if (push && full && !pop) overflow_q <= 1'b1;
    end
  end

  // FIFO storage write.
  // NOTE: the storage array is not reset; stale entries are never visible
  // because the head outputs are gated by the empty flag.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr[AW-1:0]] <= '{mask: sample_mask, data: result_voted_i, stamp: timestamp};
  end

  // Show-ahead head, driven only from registered state.
  assign head        = mem[rd_ptr[AW-1:0]];
  assign evt_valid_o = !empty;
  assign evt_mask_o  = empty ? 4'd0  : head.mask;
  assign evt_data_o  = empty ? 32'd0 : head.data;
  assign evt_time_o  = empty ? 32'd0 : head.stamp;
  assign overflow_o  = overflow_q;

endmodule

// File: tb/tb_tmr_fault_monitor.sv
// Self-checking bench for tmr_fault_monitor: directed scenarios plus a
// randomized run compared against a queue-based behavioural model.
module tb_tmr_fault_monitor;

  localparam int T     = 4;
  localparam int DEPTH = 8;
  localparam int CW    = 6;
  localparam int CMAX  = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          sys_reset = 1'b0;
  logic          valid = 1'b0;
  logic [31:0]   data = '0;
  logic          fa = 1'b0, fb = 1'b0, fc = 1'b0, fs = 1'b0;
  logic          ready = 1'b0;
  logic          ack = 1'b0;
  logic [CW-1:0] cnt_a, cnt_b, cnt_c, cnt_s;
  logic [2:0]    persistent;
  logic          evt_valid;
  logic [3:0]    evt_mask;
  logic [31:0]   evt_data, evt_time;
  logic          overflow, req;
  wire  [CW-1:0] dut_cnt [4];

  int checks = 0;
  int errors = 0;

  assign dut_cnt[0] = cnt_a;
  assign dut_cnt[1] = cnt_b;
  assign dut_cnt[2] = cnt_c;
  assign dut_cnt[3] = cnt_s;

  tmr_fault_monitor #(.PERSIST_THRESH(T), .FIFO_DEPTH(DEPTH), .CNT_WIDTH(CW)) dut (
    .clk(clk), .sys_reset_i(sys_reset), .valid_i(valid), .result_voted_i(data),
    .fault_A_i(fa), .fault_B_i(fb), .fault_C_i(fc), .system_fault_i(fs),
    .fail_count_A_o(cnt_a), .fail_count_B_o(cnt_b), .fail_count_C_o(cnt_c),
    .fail_count_sys_o(cnt_s), .persistent_o(persistent), .evt_valid_o(evt_valid),
    .evt_ready_i(ready), .evt_mask_o(evt_mask), .evt_data_o(evt_data),
    .evt_time_o(evt_time), .overflow_o(overflow), .recover_req_o(req),
    .recover_ack_i(ack)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural reference model ----------------
  typedef struct {
    bit [3:0]  mask;
    bit [31:0] data;
    bit [31:0] stamp;
  } ev_t;

  ev_t       m_q[$];
  int        m_cnt[4];
  int        m_streak[3];
  bit [2:0]  m_pers;
  int        m_mode;      // 0: idle, 1: waiting for ack, 2: clearing
  bit        m_sys_prev;
  bit        m_ovf;
  bit [31:0] m_ts;

  task automatic model_step();
    bit [3:0] mk;
    bit       do_pop;
    int       next_mode;
    ev_t      e;
    if (sys_reset) begin
      m_q.delete();
      for (int i = 0; i < 4; i++) m_cnt[i] = 0;
      for (int i = 0; i < 3; i++) m_streak[i] = 0;
      m_pers = '0; m_mode = 0; m_sys_prev = 0; m_ovf = 0; m_ts = '0;
      return;
    end
    mk = {fs, fc, fb, fa};
    do_pop = (m_q.size() > 0) && ready;
    if (do_pop) void'(m_q.pop_front());
    if (valid && mk != 0) begin
      if (m_q.size() < DEPTH) begin
        e.mask = mk; e.data = data; e.stamp = m_ts;
        m_q.push_back(e);
      end else begin
        m_ovf = 1;
      end
    end
    if (valid) for (int i = 0; i < 4; i++) if (mk[i] && m_cnt[i] < CMAX) m_cnt[i]++;
    next_mode = m_mode;
    case (m_mode)
      0: if (m_pers != 0 || m_sys_prev) next_mode = 1;
      1: if (ack) next_mode = 2;
      default: next_mode = 0;
    endcase
    if (m_mode == 2) begin
      for (int i = 0; i < 3; i++) m_streak[i] = 0;
      m_pers = '0;
    end else if (valid) begin
      for (int i = 0; i < 3; i++) begin
        if (mk[i]) begin
          if (m_streak[i] < T) m_streak[i]++;
          if (m_streak[i] == T) m_pers[i] = 1;
        end else begin
          m_streak[i] = 0;
        end
      end
    end
    m_mode = next_mode;
    m_sys_prev = valid && fs;
    m_ts++;
  endtask

  // Advance one clock; the model consumes the same inputs the DUT samples.
  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_sample(input bit v, input bit a, input bit b, input bit c,
                            input bit s, input bit [31:0] d);
    valid = v; fa = a; fb = b; fc = c; fs = s; data = d;
  endtask

  task automatic do_reset();
    set_sample(0, 0, 0, 0, 0, 0);
    ready = 0; ack = 0; sys_reset = 1;
    tick();
    tick();
    sys_reset = 0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    do_reset();
    for (int i = 0; i < 10; i++) tick();
    checks++;
    if ({cnt_a, cnt_b, cnt_c, cnt_s, persistent, evt_valid, evt_mask, evt_data,
         evt_time, overflow, req} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: cnt=%0d/%0d/%0d/%0d pers=%b ev=%b m=%h d=%h t=%0d ovf=%b req=%b, required all 0",
               cnt_a, cnt_b, cnt_c, cnt_s, persistent, evt_valid, evt_mask, evt_data, evt_time, overflow, req);
    end
    ready = 1;
    set_sample(1, 0, 0, 1, 0, 32'h1234_5678);
    tick();
    checks++;
    if (evt_time !== 32'd10 || evt_mask !== 4'h4) begin
      errors++;
      $display("FAIL reset_timestamp: time=%0d mask=%h, required time=10 mask=4", evt_time, evt_mask);
    end
    set_sample(0, 0, 0, 0, 0, 0);
    tick();
  endtask

  task automatic test_single_event();
    do_reset();
    ready = 1;
    while (m_ts != 32'd20) tick();
    set_sample(1, 0, 1, 0, 0, 32'hDEAD_BEEF);
    tick();
    set_sample(0, 0, 0, 0, 0, 0);
    checks++;
    if (evt_valid !== 1'b1 || evt_mask !== 4'h2 || evt_data !== 32'hDEAD_BEEF || evt_time !== 32'd20) begin
      errors++;
      $display("FAIL single_event: v=%b mask=%h data=%h time=%0d, required 1/2/deadbeef/20",
               evt_valid, evt_mask, evt_data, evt_time);
    end
    checks++;
    if (cnt_b !== 6'd1 || persistent !== 3'b000) begin
      errors++;
      $display("FAIL single_counts: cnt_b=%0d pers=%b, required 1/000", cnt_b, persistent);
    end
    tick();
    checks++;
    if (evt_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_drained: evt_valid=%b, required 0", evt_valid);
    end
  endtask

  task automatic test_persistent();
    do_reset();
    ready = 1;
    for (int i = 0; i < 4; i++) begin
      set_sample(1, 1, 0, 0, 0, 32'(i));
      tick();
    end
    set_sample(0, 0, 0, 0, 0, 0);
    checks++;
    if (persistent !== 3'b001 || req !== 1'b0 || cnt_a !== 6'd4) begin
      errors++;
      $display("FAIL persist_set: pers=%b req=%b cnt_a=%0d, required 001/0/4", persistent, req, cnt_a);
    end
    tick();
    checks++;
    if (req !== 1'b1) begin
      errors++;
      $display("FAIL persist_req: req=%b, required 1", req);
    end
    tick();
    tick();
    checks++;
    if (req !== 1'b1) begin
      errors++;
      $display("FAIL persist_req_hold: req=%b, required 1", req);
    end
    ack = 1;
    tick();
    ack = 0;
    checks++;
    if (req !== 1'b0 || persistent !== 3'b001) begin
      errors++;
      $display("FAIL persist_ack: req=%b pers=%b, required 0/001", req, persistent);
    end
    tick();
    checks++;
    if (persistent !== 3'b000 || cnt_a !== 6'd4 || req !== 1'b0) begin
      errors++;
      $display("FAIL persist_clear: pers=%b cnt_a=%0d req=%b, required 000/4/0", persistent, cnt_a, req);
    end
  endtask

  task automatic test_streak_break();
    do_reset();
    ready = 1;
    for (int i = 0; i < 7; i++) begin
      if (i == 3) set_sample(1, 0, 0, 0, 0, 32'hC1EA_0000);
      else        set_sample(1, 1, 0, 0, 0, 32'(i));
      tick();
      checks++;
      if (persistent !== 3'b000) begin
        errors++;
        $display("FAIL streak_break[%0d]: pers=%b, required 000", i, persistent);
      end
    end
    set_sample(0, 0, 0, 0, 0, 0);
    tick();
    checks++;
    if (req !== 1'b0 || cnt_a !== 6'd6) begin
      errors++;
      $display("FAIL streak_break_end: req=%b cnt_a=%0d, required 0/6", req, cnt_a);
    end
  endtask

  task automatic test_overflow();
    bit [31:0] t0, t_new, exp_t;
    do_reset();
    ready = 0;
    t0 = m_ts;
    for (int i = 0; i < 10; i++) begin
      set_sample(1, 0, 1, 0, 0, 32'(i));
      tick();
    end
    set_sample(0, 0, 0, 0, 0, 0);
    checks++;
    if (evt_valid !== 1'b1 || overflow !== 1'b1 || evt_time !== t0 || evt_data !== 32'd0) begin
      errors++;
      $display("FAIL overflow_full: v=%b ovf=%b time=%0d data=%0d, required 1/1/%0d/0",
               evt_valid, overflow, evt_time, evt_data, t0);
    end
    ready = 1;
    t_new = m_ts;
    set_sample(1, 0, 1, 0, 0, 32'd100);
    tick();
    set_sample(0, 0, 0, 0, 0, 0);
    checks++;
    if (evt_time !== t0 + 32'd1 || overflow !== 1'b1) begin
      errors++;
      $display("FAIL overflow_pushpop: time=%0d ovf=%b, required %0d/1", evt_time, overflow, t0 + 32'd1);
    end
    for (int k = 0; k < 8; k++) begin
      exp_t = (k < 7) ? t0 + 32'(k + 1) : t_new;
      checks++;
      if (evt_valid !== 1'b1 || evt_time !== exp_t || evt_mask !== 4'h2) begin
        errors++;
        $display("FAIL drain[%0d]: v=%b time=%0d mask=%h, required 1/%0d/2", k, evt_valid, evt_time, evt_mask, exp_t);
      end
      tick();
    end
    checks++;
    if (evt_valid !== 1'b0) begin
      errors++;
      $display("FAIL drain_empty: evt_valid=%b, required 0", evt_valid);
    end
  endtask

  task automatic test_system_fault();
    do_reset();
    ready = 0;
    set_sample(1, 0, 0, 0, 1, 32'h5A5A_A5A5);
    tick();
    set_sample(0, 0, 0, 0, 0, 0);
    checks++;
    if (evt_mask !== 4'h8 || cnt_s !== 6'd1 || req !== 1'b0) begin
      errors++;
      $display("FAIL sysfault_sample: mask=%h cnt_sys=%0d req=%b, required 8/1/0", evt_mask, cnt_s, req);
    end
    tick();
    checks++;
    if (req !== 1'b1) begin
      errors++;
      $display("FAIL sysfault_req: req=%b, required 1", req);
    end
    sys_reset = 1;
    tick();
    sys_reset = 0;
    checks++;
    if ({cnt_a, cnt_b, cnt_c, cnt_s, persistent, evt_valid, evt_mask, evt_data,
         evt_time, overflow, req} !== '0) begin
      errors++;
      $display("FAIL sysfault_reset: cnt_sys=%0d ev=%b m=%h ovf=%b req=%b, required all 0",
               cnt_s, evt_valid, evt_mask, overflow, req);
    end
  endtask

  task automatic test_random();
    ev_t e;
    do_reset();
    for (int n = 0; n < 800; n++) begin
      sys_reset = ($urandom_range(0, 299) == 0);
      valid = ($urandom_range(0, 3) != 0);
      fa    = ($urandom_range(0, 2) == 0);
      fb    = ($urandom_range(0, 2) == 0);
      fc    = ($urandom_range(0, 2) == 0);
      fs    = ($urandom_range(0, 15) == 0);
      data  = $urandom;
      ready = ($urandom_range(0, 2) != 0);
      ack   = ($urandom_range(0, 3) == 0);
      tick();
      e.mask = '0; e.data = '0; e.stamp = '0;
      if (m_q.size() != 0) e = m_q[0];
      checks++;
      if (evt_valid !== (m_q.size() != 0) || evt_mask !== e.mask || evt_data !== e.data ||
          evt_time !== e.stamp || overflow !== m_ovf) begin
        errors++;
        $display("FAIL rand_fifo[%0d]: v=%b m=%h d=%h t=%0d ovf=%b, required %b/%h/%h/%0d/%b",
                 n, evt_valid, evt_mask, evt_data, evt_time, overflow,
                 m_q.size() != 0, e.mask, e.data, e.stamp, m_ovf);
      end
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (dut_cnt[i] !== CW'(m_cnt[i])) begin
          errors++;
          $display("FAIL rand_cnt%0d[%0d]: got %0d, required %0d", i, n, dut_cnt[i], m_cnt[i]);
        end
      end
      checks++;
      if (persistent !== m_pers || req !== (m_mode == 1)) begin
        errors++;
        $display("FAIL rand_recovery[%0d]: pers=%b req=%b, required %b/%b", n, persistent, req, m_pers, m_mode == 1);
      end
    end
    sys_reset = 0;
  endtask

  initial begin
    test_reset();
    test_single_event();
    test_persistent();
    test_streak_break();
    test_overflow();
    test_system_fault();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
